// File: rtl/clock_gate_ctrl_pkg.sv
// Shared types and sizing helpers for the clock-gating sequencer.
package clock_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } cgc_state_e;

    // Counters must reach the larger of the timeout and wake durations without wrapping.
    function automatic int cgc_cnt_width(input int timeout, input int wake);
        int maxVal;
        maxVal = (timeout > wake) ? timeout : wake;
        return $clog2(maxVal) + 1;
    endfunction

endpackage

// File: rtl/clock_gate_ctrl_chan.sv
// One clock domain: RUN -> DRAIN -> GATED -> WAKE sequencer with its own counters.
module clock_gate_ctrl_chan
    import clock_gate_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = 4,
    parameter int WAKE_CYCLES = 8,
    parameter int TIMEOUT     = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic gate_req_i,
    input  logic idle_i,
    output logic clk_en_o,
    output logic gate_ack_o,
    output logic chk_gate_o,
    output logic timeout_err_o,
    output logic busy_o
);

    localparam int CW = cgc_cnt_width(TIMEOUT, WAKE_CYCLES);

    cgc_state_e    state_q, state_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [CW-1:0] wake_cnt_q, wake_cnt_d;
    logic          armed_q, armed_d;
    logic          tmo_fire;
    logic          clk_en_q, gate_ack_q, chk_gate_q, timeout_err_q, busy_q;

    function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        wake_cnt_d = wake_cnt_q;
        armed_d    = armed_q;
        tmo_fire   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (!gate_req_i) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d    = DRAIN;
                    idle_cnt_d = '0;
                    tmo_cnt_d  = '0;
                end
            end
            DRAIN: begin
                tmo_cnt_d  = satInc(tmo_cnt_q);
                idle_cnt_d = idle_i ? satInc(idle_cnt_q) : '0;
                // Withdrawal beats qualification, which beats the timeout abort.
                if (!gate_req_i) begin
                    state_d = RUN;
                end else if (idle_i && idle_cnt_q == CW'(IDLE_CYCLES - 1)) begin
                    state_d = GATED;
                end else if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d  = RUN;
                    tmo_fire = 1'b1;
                    armed_d  = 1'b0;
                end
            end
            GATED: begin
                if (!gate_req_i) begin
                    state_d    = WAKE;
                    wake_cnt_d = '0;
                end
            end
            WAKE: begin
                wake_cnt_d = satInc(wake_cnt_q);
                if (wake_cnt_q == CW'(WAKE_CYCLES - 1)) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs are decoded from the settled state, so they trail the state register by one edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= RUN;
            idle_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            wake_cnt_q    <= '0;
            armed_q       <= 1'b1;
            clk_en_q      <= 1'b1;
            gate_ack_q    <= 1'b0;
            chk_gate_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idle_cnt_q    <= idle_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            wake_cnt_q    <= wake_cnt_d;
            armed_q       <= armed_d;
            clk_en_q      <= (state_q != GATED);
            gate_ack_q    <= (state_q == GATED) || (state_q == WAKE);
            chk_gate_q    <= (state_q == GATED);
            timeout_err_q <= tmo_fire;
            busy_q        <= (state_q != RUN);
        end
    end

    assign clk_en_o      = clk_en_q;
    assign gate_ack_o    = gate_ack_q;
    assign chk_gate_o    = chk_gate_q;
    assign timeout_err_o = timeout_err_q;
    assign busy_o        = busy_q;

endmodule

// File: rtl/clock_gate_ctrl.sv
// Per-domain clock-gating sequencer: one independent channel per gated clock domain.
module clock_gate_ctrl
    import clock_gate_ctrl_pkg::*;
#(
    parameter int N_CLK       = 2,
    parameter int IDLE_CYCLES = 4,
    parameter int WAKE_CYCLES = 8,
    parameter int TIMEOUT     = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_CLK-1:0] gate_req_i,
    input  logic [N_CLK-1:0] idle_i,
    output logic [N_CLK-1:0] clk_en_o,
    output logic [N_CLK-1:0] gate_ack_o,
    output logic [N_CLK-1:0] chk_gate_o,
    output logic [N_CLK-1:0] timeout_err_o,
    output logic             busy_o
);

    if (IDLE_CYCLES < 1) begin : g_badIdle
        $error("clock_gate_ctrl: IDLE_CYCLES must be >= 1");
    end
    if (WAKE_CYCLES < 1) begin : g_badWake
        $error("clock_gate_ctrl: WAKE_CYCLES must be >= 1");
    end
    if (TIMEOUT <= IDLE_CYCLES) begin : g_badTimeout
        $error("clock_gate_ctrl: TIMEOUT must exceed IDLE_CYCLES");
    end

    logic [N_CLK-1:0] chanBusy;

    for (genvar i = 0; i < N_CLK; i++) begin : g_chan
        clock_gate_ctrl_chan #(
            .IDLE_CYCLES (IDLE_CYCLES),
            .WAKE_CYCLES (WAKE_CYCLES),
            .TIMEOUT     (TIMEOUT)
        ) u_chan (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .gate_req_i    (gate_req_i[i]),
            .idle_i        (idle_i[i]),
            .clk_en_o      (clk_en_o[i]),
            .gate_ack_o    (gate_ack_o[i]),
            .chk_gate_o    (chk_gate_o[i]),
            .timeout_err_o (timeout_err_o[i]),
            .busy_o        (chanBusy[i])
        );
    end

    assign busy_o = |chanBusy;

endmodule
